// File: rtl/cdbus_rx_framer_pkg.sv
// rtl/cdbus_rx_framer_pkg.sv - shared constants, state encoding and flag helper for the CDBUS RX framer
package cdbus_rx_framer_pkg;

  // CRC16 (reflected 0x8005) as used on the bus; residue over data+crc is zero
  localparam logic [15:0] CRC16_POLY = 16'hA001;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  localparam logic [7:0] BCAST_ADDR = 8'hFF;

  // Header byte offsets and per-frame overhead (src, dst, len, crc_lo, crc_hi)
  localparam int unsigned HDR_SRC        = 0;
  localparam int unsigned HDR_DST        = 1;
  localparam int unsigned HDR_LEN        = 2;
  localparam int unsigned FRAME_OVERHEAD = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RECV     = 3'd1,
    ST_WAIT_END = 3'd2,
    ST_DROP     = 3'd3,
    ST_COMMIT   = 3'd4
  } state_e;

  // wr_flags bit positions
  localparam int unsigned FLAG_BCAST   = 0;
  localparam int unsigned FLAG_PROMISC = 1;

  // Flags handed to the RAM with a committed frame
  function automatic logic [7:0] make_flags(input logic [7:0] dst, input logic [7:0] self_addr);
    logic [7:0] f;
    f = 8'h00;
    f[FLAG_BCAST]   = (dst == BCAST_ADDR);
    f[FLAG_PROMISC] = (dst != self_addr) && (dst != BCAST_ADDR);
    return f;
  endfunction

endpackage

// File: rtl/cdbus_rx_framer_if.sv
// rtl/cdbus_rx_framer_if.sv - byte receiver and RX RAM write-side signals of the CDBUS RX framer
interface cdbus_rx_framer_if #(
  parameter int A_WIDTH = 8
);
  logic [7:0]         rx_byte;
  logic               rx_valid;
  logic               rx_idle;
  logic               rx_err;
  logic [7:0]         wr_byte;
  logic [A_WIDTH-1:0] wr_addr;
  logic               wr_en;
  logic               switch;
  logic [7:0]         wr_flags;
  logic               switch_fail;

  // Framer side
  modport slave (
    input  rx_byte, rx_valid, rx_idle, rx_err, switch_fail,
    output wr_byte, wr_addr, wr_en, switch, wr_flags
  );

  // Receiver/RAM environment side
  modport master (
    output rx_byte, rx_valid, rx_idle, rx_err, switch_fail,
    input  wr_byte, wr_addr, wr_en, switch, wr_flags
  );
endinterface

// File: rtl/cdbus_rx_framer_crc16_byte.sv
// rtl/cdbus_rx_framer_crc16_byte.sv - combinational CRC16 update by one byte, LSB first
module cdbus_rx_framer_crc16_byte
  import cdbus_rx_framer_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  // Eight unrolled shift/xor steps of the reflected polynomial
  always_comb begin : crc_steps
    logic [15:0] c;
    c = crc_in ^ {8'h00, data_in};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/cdbus_rx_framer.sv
// rtl/cdbus_rx_framer.sv - CDBUS RX frame assembler/checker; CDRX_ADDR_FILTER_EN enables dst filtering
module cdbus_rx_framer
  import cdbus_rx_framer_pkg::*;
#(
  parameter int A_WIDTH   = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  cdbus_rx_framer_if.slave     bus,
  input  logic [7:0]           self_addr,
  input  logic                 promisc,
  output logic [CNT_WIDTH-1:0] cnt_crc_err,
  output logic [CNT_WIDTH-1:0] cnt_len_err,
  output logic [CNT_WIDTH-1:0] cnt_lost,
  output logic                 frame_ok
);

  // Index/total need one extra bit: a full frame is exactly 2**A_WIDTH bytes
  localparam int          IW      = A_WIDTH + 1;
  localparam int unsigned MAX_LEN = (32'd1 << A_WIDTH) - FRAME_OVERHEAD;

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        total_q, total_d;
  logic [15:0]          crc_q, crc_d;
  logic [7:0]           dst_q, dst_d;
  logic                 pend_q, pend_d;
  logic [7:0]           wr_byte_q, wr_byte_d;
  logic [A_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic                 wr_en_q, wr_en_d;
  logic                 switch_q, switch_d;
  logic                 frame_ok_q, frame_ok_d;
  logic [7:0]           wr_flags_q, wr_flags_d;
  logic                 sw_prev_q, sw_prev_d;
  logic [CNT_WIDTH-1:0] cnt_crc_q, cnt_crc_d;
  logic [CNT_WIDTH-1:0] cnt_len_q, cnt_len_d;
  logic [CNT_WIDTH-1:0] cnt_lost_q, cnt_lost_d;

  logic [15:0] crc_base, crc_upd;
  logic        idle_now, addr_miss, filt_drop, len_too_long;
  logic        len_inc, crc_inc;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Byte 0 of a frame restarts the CRC; later bytes chain onto the running value
  assign crc_base = (state_q == ST_RECV) ? crc_q : CRC16_INIT;

  cdbus_rx_framer_crc16_byte u_crc (
    .crc_in  (crc_base),
    .data_in (bus.rx_byte),
    .crc_out (crc_upd)
  );

  assign addr_miss    = (bus.rx_byte != self_addr) && (bus.rx_byte != BCAST_ADDR) && !promisc;
  assign len_too_long = 32'(bus.rx_byte) > MAX_LEN;
  // A pending idle (seen together with a byte) is handled one cycle later
  assign idle_now     = bus.rx_idle | pend_q;

`ifdef CDRX_ADDR_FILTER_EN
  assign filt_drop = addr_miss;
`else
  // Filtering compiled out; the miss term is kept referenced but never drops
  assign filt_drop = 1'b0 & addr_miss;
`endif

  // Next-state, write-port and counter logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    total_d    = total_q;
    crc_d      = crc_q;
    dst_d      = dst_q;
    pend_d     = 1'b0;
    wr_byte_d  = wr_byte_q;
    wr_addr_d  = wr_addr_q;
    wr_en_d    = 1'b0;
    switch_d   = 1'b0;
    frame_ok_d = 1'b0;
    wr_flags_d = wr_flags_q;
    sw_prev_d  = switch_q;
    len_inc    = 1'b0;
    crc_inc    = 1'b0;

    case (state_q)
      ST_IDLE, ST_COMMIT: begin
        // COMMIT lasts one cycle; a byte arriving in it starts the next frame
        state_d = ST_IDLE;
        if (bus.rx_valid) begin
          wr_en_d   = 1'b1;
          wr_byte_d = bus.rx_byte;
          wr_addr_d = A_WIDTH'(HDR_SRC);
          crc_d     = crc_upd;
          idx_d     = IW'(1);
          state_d   = ST_RECV;
          pend_d    = bus.rx_idle;
        end
      end

      ST_RECV: begin
        if (bus.rx_err) begin
          state_d = ST_DROP;
          pend_d  = idle_now;
        end else if (bus.rx_valid) begin
          wr_en_d   = 1'b1;
          wr_byte_d = bus.rx_byte;
          wr_addr_d = idx_q[A_WIDTH-1:0];
          crc_d     = crc_upd;
          idx_d     = idx_q + 1'b1;
          pend_d    = idle_now;
          if (idx_q == IW'(HDR_DST)) begin
            dst_d = bus.rx_byte;
            if (filt_drop) state_d = ST_DROP;
          end else if (idx_q == IW'(HDR_LEN)) begin
            if (len_too_long) begin
              state_d = ST_DROP;
              len_inc = 1'b1;
            end else begin
              total_d = IW'(bus.rx_byte) + IW'(FRAME_OVERHEAD);
            end
          end else if (idx_q + 1'b1 == total_q) begin
            state_d = ST_WAIT_END;
          end
        end else if (idle_now) begin
          state_d = ST_IDLE;
          len_inc = 1'b1;
        end
      end

      ST_WAIT_END: begin
        if (bus.rx_err) begin
          state_d = ST_DROP;
          pend_d  = idle_now;
        end else if (bus.rx_valid) begin
          state_d = ST_DROP;
          len_inc = 1'b1;
          pend_d  = idle_now;
        end else if (idle_now) begin
          if (crc_q == 16'h0000) begin
            state_d    = ST_COMMIT;
            switch_d   = 1'b1;
            frame_ok_d = 1'b1;
            wr_flags_d = make_flags(dst_q, self_addr);
          end else begin
            state_d = ST_IDLE;
            crc_inc = 1'b1;
          end
        end
      end

      ST_DROP: begin
        if (idle_now) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    cnt_len_d  = len_inc ? sat_inc(cnt_len_q) : cnt_len_q;
    cnt_crc_d  = crc_inc ? sat_inc(cnt_crc_q) : cnt_crc_q;
    cnt_lost_d = (sw_prev_q && bus.switch_fail) ? sat_inc(cnt_lost_q) : cnt_lost_q;
  end

  // State and registered outputs; reset abandons any frame in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      total_q    <= '0;
      crc_q      <= CRC16_INIT;
      dst_q      <= 8'h00;
      pend_q     <= 1'b0;
      wr_byte_q  <= 8'h00;
      wr_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      switch_q   <= 1'b0;
      frame_ok_q <= 1'b0;
      wr_flags_q <= 8'h00;
      sw_prev_q  <= 1'b0;
      cnt_crc_q  <= '0;
      cnt_len_q  <= '0;
      cnt_lost_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      total_q    <= total_d;
      crc_q      <= crc_d;
      dst_q      <= dst_d;
      pend_q     <= pend_d;
      wr_byte_q  <= wr_byte_d;
      wr_addr_q  <= wr_addr_d;
      wr_en_q    <= wr_en_d;
      switch_q   <= switch_d;
      frame_ok_q <= frame_ok_d;
      wr_flags_q <= wr_flags_d;
      sw_prev_q  <= sw_prev_d;
      cnt_crc_q  <= cnt_crc_d;
      cnt_len_q  <= cnt_len_d;
      cnt_lost_q <= cnt_lost_d;
    end
  end

  assign bus.wr_byte  = wr_byte_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.switch   = switch_q;
  assign bus.wr_flags = wr_flags_q;
  assign frame_ok     = frame_ok_q;
  assign cnt_crc_err  = cnt_crc_q;
  assign cnt_len_err  = cnt_len_q;
  assign cnt_lost     = cnt_lost_q;

endmodule

// File: tb/tb_cdbus_rx_framer.sv
// tb/tb_cdbus_rx_framer.sv - directed self-checking bench for cdbus_rx_framer (A_WIDTH 8 and 4)
module tb_cdbus_rx_framer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] self_addr;
  logic       promisc;
  logic       frame_ok, frame_ok4;
  logic [7:0] cnt_crc, cnt_len, cnt_lost;
  logic [7:0] cnt_crc4, cnt_len4, cnt_lost4;

  cdbus_rx_framer_if #(.A_WIDTH(8)) bus ();
  cdbus_rx_framer_if #(.A_WIDTH(4)) bus4 ();

  assign bus4.rx_byte     = bus.rx_byte;
  assign bus4.rx_valid    = bus.rx_valid;
  assign bus4.rx_idle     = bus.rx_idle;
  assign bus4.rx_err      = bus.rx_err;
  assign bus4.switch_fail = bus.switch_fail;

  cdbus_rx_framer #(.A_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .self_addr(self_addr), .promisc(promisc),
    .cnt_crc_err(cnt_crc), .cnt_len_err(cnt_len), .cnt_lost(cnt_lost), .frame_ok(frame_ok)
  );

  cdbus_rx_framer #(.A_WIDTH(4), .CNT_WIDTH(8)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(bus4), .self_addr(self_addr), .promisc(promisc),
    .cnt_crc_err(cnt_crc4), .cnt_len_err(cnt_len4), .cnt_lost(cnt_lost4), .frame_ok(frame_ok4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int         nwr = 0, nsw = 0, nfok = 0, nsw4 = 0;
  logic [7:0] log_addr [0:255];
  logic [7:0] log_byte [0:255];
  logic [7:0] last_flags = 8'h00;
  logic [3:0] last_addr4 = 4'h0;

  always @(negedge clk) begin
    if (bus.wr_en === 1'b1 && nwr < 256) begin
      log_addr[nwr] <= bus.wr_addr;
      log_byte[nwr] <= bus.wr_byte;
      nwr <= nwr + 1;
    end
    if (bus.switch === 1'b1) begin
      nsw <= nsw + 1;
      last_flags <= bus.wr_flags;
    end
    if (frame_ok === 1'b1) nfok <= nfok + 1;
    if (bus4.switch === 1'b1) nsw4 <= nsw4 + 1;
    if (bus4.wr_en === 1'b1) last_addr4 <= bus4.wr_addr;
  end

  logic [7:0] fr [0:31];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] crc16(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {8'h00, fr[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic build(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] len);
    logic [15:0] c;
    fr[0] = src; fr[1] = dst; fr[2] = len;
    for (int i = 0; i < int'(len); i++) fr[3+i] = 8'h10 + 8'(i);
    c = crc16(3 + int'(len));
    fr[3+int'(len)] = c[7:0];
    fr[4+int'(len)] = c[15:8];
  endtask

  task automatic drive(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_byte  = fr[i];
      @(negedge clk);
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic idle_pulse();
    bus.rx_idle = 1'b1;
    @(negedge clk);
    bus.rx_idle = 1'b0;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_writes(input string tag, input int n0, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 32'(log_addr[n0+i]), 32'(i));
      chk($sformatf("%s_byte%0d", tag, i), 32'(log_byte[n0+i]), 32'(fr[i]));
    end
  endtask

  int n0, s0, f0, s40;

  task automatic snap();
    n0 = nwr; s0 = nsw; f0 = nfok; s40 = nsw4;
  endtask

  initial begin
    reset_n = 1'b0;
    self_addr = 8'h05;
    promisc = 1'b0;
    bus.rx_byte = 8'h00; bus.rx_valid = 1'b0; bus.rx_idle = 1'b0;
    bus.rx_err = 1'b0; bus.switch_fail = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_switch", 32'(bus.switch), 0);
    chk("rst_frame_ok", 32'(frame_ok), 0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 0);
    chk("rst_wr_flags", 32'(bus.wr_flags), 0);
    chk("rst_cnt_len", 32'(cnt_len), 0);
    reset_n = 1'b1;
    settle();

    // 1: good frame to self
    build(8'h01, 8'h05, 8'h02); fr[3] = 8'hAA; fr[4] = 8'hBB;
    begin logic [15:0] c; c = crc16(5); fr[5] = c[7:0]; fr[6] = c[15:8]; end
    snap(); drive(0, 7); idle_pulse(); settle();
    chk("t1_nwrites", 32'(nwr - n0), 7);
    chk_writes("t1", n0, 7);
    chk("t1_switch", 32'(nsw - s0), 1);
    chk("t1_frame_ok", 32'(nfok - f0), 1);
    chk("t1_flags", 32'(last_flags), 32'h00);

    // 2: corrupted crc_hi
    fr[6] = fr[6] ^ 8'h01;
    snap(); drive(0, 7); idle_pulse(); settle();
    chk("t2_switch", 32'(nsw - s0), 0);
    chk("t2_cnt_crc", 32'(cnt_crc), 1);
    chk("t2_nwrites", 32'(nwr - n0), 7);
    chk_writes("t2", n0, 7);

    // 3: foreign dst, broadcast dst, promiscuous
    build(8'h01, 8'h07, 8'h02);
    snap(); drive(0, 7); idle_pulse(); settle();
`ifdef CDRX_ADDR_FILTER_EN
    chk("t3_filt_nwrites", 32'(nwr - n0), 2);
    chk("t3_filt_switch", 32'(nsw - s0), 0);
`else
    chk("t3_nofilt_nwrites", 32'(nwr - n0), 7);
    chk("t3_nofilt_switch", 32'(nsw - s0), 1);
    chk("t3_nofilt_flags", 32'(last_flags), 32'h02);
`endif
    chk("t3_cnt_crc", 32'(cnt_crc), 1);
    chk("t3_cnt_len", 32'(cnt_len), 0);
    build(8'h01, 8'hFF, 8'h02);
    snap(); drive(0, 7); idle_pulse(); settle();
    chk("t3_bcast_switch", 32'(nsw - s0), 1);
    chk("t3_bcast_flags", 32'(last_flags), 32'h01);
    promisc = 1'b1;
    build(8'h01, 8'h07, 8'h01);
    snap(); drive(0, 6); idle_pulse(); settle();
    chk("t3_promisc_switch", 32'(nsw - s0), 1);
    chk("t3_promisc_flags", 32'(last_flags), 32'h02);
    promisc = 1'b0;

    // 4: length errors
    build(8'h01, 8'h05, 8'h03);
    snap(); drive(0, 6); idle_pulse(); settle();
    chk("t4_short_switch", 32'(nsw - s0), 0);
    chk("t4_short_cnt_len", 32'(cnt_len), 1);
    build(8'h01, 8'h05, 8'h02); fr[7] = 8'h55; fr[8] = 8'h66;
    snap(); drive(0, 9); idle_pulse(); settle();
    chk("t4_long_switch", 32'(nsw - s0), 0);
    chk("t4_long_nwrites", 32'(nwr - n0), 7);
    chk("t4_long_cnt_len", 32'(cnt_len), 2);
    build(8'h01, 8'h05, 8'h0B);
    snap(); drive(0, 16); idle_pulse(); settle();
    chk("t4_a4max_switch", 32'(nsw4 - s40), 1);
    chk("t4_a4max_last_addr", 32'(last_addr4), 15);
    chk("t4_a8_len11_switch", 32'(nsw - s0), 1);
    build(8'h01, 8'h05, 8'h0C);
    snap(); drive(0, 17); idle_pulse(); settle();
    chk("t4_a4over_switch", 32'(nsw4 - s40), 0);
    chk("t4_a4over_cnt_len", 32'(cnt_len4), 3);
    chk("t4_a8_len12_switch", 32'(nsw - s0), 1);
    chk("t4_a8_cnt_len", 32'(cnt_len), 2);

    // 5: switch_fail, byte+idle together, back-to-back across COMMIT
    build(8'h01, 8'h05, 8'h02);
    drive(0, 7); idle_pulse();
    chk("t5_switch_now", 32'(bus.switch), 1);
    @(negedge clk); bus.switch_fail = 1'b1;
    @(negedge clk); bus.switch_fail = 1'b0;
    settle();
    chk("t5_cnt_lost", 32'(cnt_lost), 1);
    snap(); drive(0, 6);
    bus.rx_valid = 1'b1; bus.rx_byte = fr[6]; bus.rx_idle = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0; bus.rx_idle = 1'b0;
    settle();
    chk("t5_same_cycle_switch", 32'(nsw - s0), 1);
    snap(); drive(0, 7); idle_pulse();
    build(8'h09, 8'h05, 8'h02);
    drive(0, 7); idle_pulse(); settle();
    chk("t5_b2b_switch", 32'(nsw - s0), 2);
    chk("t5_b2b_nwrites", 32'(nwr - n0), 14);
    chk("t5_b2b_addr0", 32'(log_addr[n0+7]), 0);
    chk("t5_b2b_byte0", 32'(log_byte[n0+7]), 32'h09);
    chk("t5_cnt_lost_hold", 32'(cnt_lost), 1);

    // 6: rx_err mid-frame, then reset mid-frame
    build(8'h01, 8'h05, 8'h02);
    snap(); drive(0, 4);
    bus.rx_err = 1'b1; @(negedge clk); bus.rx_err = 1'b0;
    drive(4, 7); idle_pulse(); settle();
    chk("t6_err_switch", 32'(nsw - s0), 0);
    chk("t6_err_cnt_crc", 32'(cnt_crc), 1);
    chk("t6_err_cnt_len", 32'(cnt_len), 2);
    drive(0, 3);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_wr_en", 32'(bus.wr_en), 0);
    chk("t6_rst_wr_addr", 32'(bus.wr_addr), 0);
    chk("t6_rst_wr_byte", 32'(bus.wr_byte), 0);
    chk("t6_rst_wr_flags", 32'(bus.wr_flags), 0);
    chk("t6_rst_switch", 32'(bus.switch), 0);
    chk("t6_rst_cnt_crc", 32'(cnt_crc), 0);
    chk("t6_rst_cnt_lost", 32'(cnt_lost), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    snap(); drive(3, 7); idle_pulse(); settle();
    chk("t6_abandon_switch", 32'(nsw - s0), 0);
    chk("t6_abandon_cnt_len", 32'(cnt_len), 1);
    snap(); drive(0, 7); idle_pulse(); settle();
    chk("t6_good_switch", 32'(nsw - s0), 1);
    chk("t6_good_nwrites", 32'(nwr - n0), 7);
    chk_writes("t6", n0, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
